jtag_tap_driver: RTL

- Host-side JTAG driver: the initiator that drives a TAP controller through its state machine.
- Accepts scan commands from a local host: reset, idle, IR scan, DR scan.
- Generates the TMS/TDI sequence on TCK, samples TDO and returns the captured bits.
- Every command starts and ends with the TAP in Run-Test/Idle (RTI); the block is the counterpart of the team's tap_ctl and drives it directly in system benches.

---
 rtl/jtag_tap_driver_if.sv | 25 ++
 rtl/jtag_tap_driver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_driver_if.sv
// Command/response bus between a local host and the JTAG TAP driver.
// Ports: cmd_valid/cmd_ready handshake with cmd_op, cmd_len, cmd_data; rsp_valid pulse with rsp_data.
// Host side uses the master modport and the driver uses the slave modport.
interface jtag_tap_driver_if #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_tap_driver.sv
// Host-side JTAG driver: walks a TAP through RESET / IDLE / IR scan / DR scan from RTI back to RTI.
// Latency: first TMS bit the cycle after acceptance; rsp_valid the cycle after the last TMS bit.
// Backpressure: cmd_ready low while a command runs; high in READY and in the rsp_valid cycle.
// Ports: tck_i clock, trst_ni sync active-low reset, bus (slave) command/response, tms_o/tdi_o/tdo_i to target.
module jtag_tap_driver #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               tck_i,
    input  logic               trst_ni,
    jtag_tap_driver_if.slave   bus,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);
    typedef enum logic [2:0] {S_INIT, S_READY, S_PRE, S_SHIFT, S_POST, S_DONE} state_t;

    localparam logic [1:0]       OP_RESET = 2'b00;
    localparam logic [1:0]       OP_IDLE  = 2'b01;
    localparam logic [1:0]       OP_IR    = 2'b10;
    localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               shift_q, shift_d;
    logic [4:0]         pat_q, pat_d;     // remaining entry TMS bits, LSB next
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;     // TDO enters at the top, right-justified at the end
    logic [MAX_LEN-1:0] rsp_q, rsp_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               cmd_rdy;
    logic               accept;
    logic [LEN_W-1:0]   n_clip;

    assign cmd_rdy       = (state_q == S_READY) || (state_q == S_DONE);
    assign accept        = bus.cmd_valid && cmd_rdy;
    assign n_clip        = (bus.cmd_len > MAX_L) ? MAX_L : bus.cmd_len;
    assign bus.cmd_ready = cmd_rdy;
    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.rsp_data  = rsp_q;
    assign tms_o         = tms_q;
    assign tdi_o         = tdi_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        shift_d = shift_q;
        pat_d   = pat_q;
        data_d  = data_q;
        cap_d   = cap_q;
        rsp_d   = rsp_q;
        tms_d   = 1'b0;
        tdi_d   = 1'b0;
        case (state_q)
            // cnt counts up here: five TMS=1 cycles, one TMS=0 cycle, then READY
            S_INIT: begin
                if (cnt_q < LEN_W'(5)) begin
                    tms_d = 1'b1;
                    cnt_d = cnt_q + ONE;
                end else if (cnt_q == LEN_W'(5)) begin
                    cnt_d = LEN_W'(6);
                end else begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end
            end
            S_READY, S_DONE: begin
                state_d = S_READY;
                if (accept) begin
                    shift_d = bus.cmd_op[1];
                    data_d  = bus.cmd_data;
                    cap_d   = '0;
                    len_d   = (bus.cmd_op[1] && n_clip == '0) ? ONE : n_clip;
                    state_d = S_PRE;
                    // First entry bit is driven now; cnt holds the number still to come.
                    case (bus.cmd_op)
                        OP_RESET: begin
                            tms_d = 1'b1;
                            pat_d = 5'b01111;
                            cnt_d = LEN_W'(5);
                        end
                        OP_IDLE: begin
                            pat_d = 5'b00000;
                            if (n_clip == '0) begin
                                state_d = S_DONE;
                                rsp_d   = '0;
                            end else begin
                                cnt_d = n_clip - ONE;
                            end
                        end
                        OP_IR: begin
                            tms_d = 1'b1;
                            pat_d = 5'b00001;
                            cnt_d = LEN_W'(3);
                        end
                        default: begin
                            tms_d = 1'b1;
                            pat_d = 5'b00000;
                            cnt_d = LEN_W'(2);
                        end
                    endcase
                end
            end
            S_PRE: begin
                if (cnt_q != '0) begin
                    tms_d = pat_q[0];
                    pat_d = pat_q >> 1;
                    cnt_d = cnt_q - ONE;
                end else if (shift_q) begin
                    state_d = S_SHIFT;
                    tms_d   = (len_q == ONE);
                    tdi_d   = data_q[0];
                    data_d  = data_q >> 1;
                    cnt_d   = len_q - ONE;
                end else begin
                    state_d = S_DONE;
                    rsp_d   = cap_q;
                end
            end
            S_SHIFT: begin
                cap_d = {tdo_i, cap_q[MAX_LEN-1:1]};
                if (cnt_q != '0) begin
                    tms_d  = (cnt_q == ONE);
                    tdi_d  = data_q[0];
                    data_d = data_q >> 1;
                    cnt_d  = cnt_q - ONE;
                end else begin
                    state_d = S_POST;
                    tms_d   = 1'b1;
                    cnt_d   = ONE;
                end
            end
            S_POST: begin
                if (cnt_q != '0) begin
                    cnt_d = '0;
                end else begin
                    state_d = S_DONE;
                    rsp_d   = cap_q >> (MAX_L - len_q);
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            len_q   <= '0;
            shift_q <= 1'b0;
            pat_q   <= '0;
            data_q  <= '0;
            cap_q   <= '0;
            rsp_q   <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            shift_q <= shift_d;
            pat_q   <= pat_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            rsp_q   <= rsp_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
        end
    end
endmodule
